// File: rtl/magnitude_pkg.sv
// Shared types and constants for the Sobel gradient-magnitude pipeline.
package magnitude_pkg;
  typedef enum logic [1:0] {
    MAG_L1        = 2'd0,
    MAG_LINF      = 2'd1,
    MAG_AMBM_HALF = 2'd2,
    MAG_AMBM_78   = 2'd3
  } mag_mode_e;

  localparam int BETA_SHIFT  = 1;
  localparam int ALPHA_SHIFT = 3;
endpackage

// File: rtl/magnitude_pipe_if.sv
// Beat-level handshake bundle between the Sobel stage, the magnitude engine and the threshold stage.
interface magnitude_pipe_if #(
  parameter int WIDTH_P     = 8,
  parameter int OUT_WIDTH_P = 8
);
  import magnitude_pkg::*;

  logic                   valid_i;
  logic                   ready_o;
  logic [WIDTH_P-1:0]     gx_i;
  logic [WIDTH_P-1:0]     gy_i;
  mag_mode_e              mode_i;
  logic [OUT_WIDTH_P-1:0] thresh_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [OUT_WIDTH_P-1:0] mag_o;
  logic                   edge_o;

  modport master (
    output valid_i, gx_i, gy_i, mode_i, thresh_i, ready_i,
    input  ready_o, valid_o, mag_o, edge_o
  );

  modport slave (
    input  valid_i, gx_i, gy_i, mode_i, thresh_i, ready_i,
    output ready_o, valid_o, mag_o, edge_o
  );
endinterface

// File: rtl/magnitude_pipe_elastic_reg.sv
// One pipeline stage: valid flag plus payload, advancing only when the stage is told to load.
module magnitude_pipe_elastic_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  // Payload only captured on a real beat so bubbles do not toggle the data path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) q <= d;
    end
  end
endmodule

// File: rtl/magnitude_pipe.sv
// Two-stage back-pressurable gradient-magnitude engine: abs in S1, select/saturate/threshold in S2.
module magnitude_pipe
  import magnitude_pkg::*;
#(
  parameter int WIDTH_P     = 8,
  parameter int OUT_WIDTH_P = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  magnitude_pipe_if.slave    bus
);
  localparam int S1_W = 2*WIDTH_P + 2 + OUT_WIDTH_P;
  localparam int S2_W = OUT_WIDTH_P + 1;
  localparam logic [WIDTH_P:0] SAT_MAX = (WIDTH_P+1)'((64'd1 << OUT_WIDTH_P) - 64'd1);

  typedef struct packed {
    mag_mode_e              mode;
    logic [OUT_WIDTH_P-1:0] thresh;
    logic [WIDTH_P-1:0]     ax;
    logic [WIDTH_P-1:0]     ay;
  } s1_t;

  typedef struct packed {
    logic [OUT_WIDTH_P-1:0] mag;
    logic                   hit;
  } s2_t;

  logic s1_valid, s2_valid, s1_load, s2_load;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  assign s2_load     = !s2_valid || bus.ready_i;
  assign s1_load     = !s1_valid || s2_load;
  assign bus.ready_o = s1_load;

  // Unsigned reinterpretation of the negated value maps -2^(W-1) onto 2^(W-1).
  assign s1_d.mode   = bus.mode_i;
  assign s1_d.thresh = bus.thresh_i;
  assign s1_d.ax     = bus.gx_i[WIDTH_P-1] ? -bus.gx_i : bus.gx_i;
  assign s1_d.ay     = bus.gy_i[WIDTH_P-1] ? -bus.gy_i : bus.gy_i;

  magnitude_pipe_elastic_reg #(.W(S1_W)) u_s1 (
    .clk(clk_i), .rst_n(rstn_i), .load(s1_load), .in_valid(bus.valid_i),
    .d(s1_d), .valid(s1_valid), .q(s1_q)
  );

  logic [WIDTH_P:0] ax_w, ay_w, mx, mn, res;

  always_comb begin
    ax_w = {1'b0, s1_q.ax};
    ay_w = {1'b0, s1_q.ay};
    mx   = (ax_w >= ay_w) ? ax_w : ay_w;
    mn   = (ax_w >= ay_w) ? ay_w : ax_w;
    res  = '0;
    case (s1_q.mode)
      MAG_L1:        res = ax_w + ay_w;
      MAG_LINF:      res = mx;
      MAG_AMBM_HALF: res = mx + (mn >> BETA_SHIFT);
      MAG_AMBM_78:   res = mx - (mx >> ALPHA_SHIFT) + (mn >> BETA_SHIFT);
      default:       res = '0;
    endcase
    s2_d.mag = (res > SAT_MAX) ? '1 : res[OUT_WIDTH_P-1:0];
    s2_d.hit = (s2_d.mag >= s1_q.thresh);
  end

  magnitude_pipe_elastic_reg #(.W(S2_W)) u_s2 (
    .clk(clk_i), .rst_n(rstn_i), .load(s2_load), .in_valid(s1_valid),
    .d(s2_d), .valid(s2_valid), .q(s2_q)
  );

  assign bus.valid_o = s2_valid;
  assign bus.mag_o   = s2_q.mag;
  assign bus.edge_o  = s2_q.hit;
endmodule

// File: tb/tb_magnitude_pipe.sv
// Directed and scoreboarded checks of the magnitude pipeline at WIDTH_P=8, OUT_WIDTH_P=8.
module tb_magnitude_pipe;
  import magnitude_pkg::*;

  localparam int W = 8;
  localparam int OW = 8;
  localparam int OMAX = (1 << OW) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  magnitude_pipe_if #(.WIDTH_P(W), .OUT_WIDTH_P(OW)) bus ();

  magnitude_pipe #(.WIDTH_P(W), .OUT_WIDTH_P(OW)) dut (
    .clk_i(clk), .rstn_i(rstn), .bus(bus)
  );

  typedef struct { int mag; int ed; } exp_t;

  function automatic int ref_mag(input int gx, input int gy, input int m);
    int ax, ay, mx, mn, r;
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mx = (ax > ay) ? ax : ay;
    mn = (ax > ay) ? ay : ax;
    case (m)
      0:       r = ax + ay;
      1:       r = mx;
      2:       r = mx + mn / 2;
      default: r = mx - mx / 8 + mn / 2;
    endcase
    return (r > OMAX) ? OMAX : r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, input int gx, input int gy, input int m, input int th);
    bus.valid_i  = v;
    bus.gx_i     = W'(gx);
    bus.gy_i     = W'(gy);
    bus.mode_i   = mag_mode_e'(m[1:0]);
    bus.thresh_i = OW'(th);
  endtask

  // Single beat into an idle pipe; returns what emerged and how many edges it took.
  task automatic run_beat(input int gx, input int gy, input int m, input int th,
                          output int mag, output int ed, output int lat);
    drive(1'b1, gx, gy, m, th);
    bus.ready_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
    lat = 1;
    while (!bus.valid_o && lat < 10) begin
      step();
      lat++;
    end
    mag = int'(bus.mag_o);
    ed  = int'(bus.edge_o);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    bus.ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid_o); end
    total++; if (bus.mag_o !== 8'd0) begin bad++; $display("FAIL reset_mag got=%0d want=0", bus.mag_o); end
    total++; if (bus.edge_o !== 1'b0) begin bad++; $display("FAIL reset_edge got=%b want=0", bus.edge_o); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ready_o); end
    step();
  endtask

  task automatic test_l1();
    int mag, ed, lat;
    run_beat(-128, 127, 0, 100, mag, ed, lat);
    total++; if (mag !== 255) begin bad++; $display("FAIL l1_sat_mag got=%0d want=255", mag); end
    total++; if (ed !== 1) begin bad++; $display("FAIL l1_sat_edge got=%0d want=1", ed); end
    total++; if (lat !== 2) begin bad++; $display("FAIL l1_sat_latency got=%0d want=2", lat); end
    run_beat(30, -40, 0, 100, mag, ed, lat);
    total++; if (mag !== 70) begin bad++; $display("FAIL l1_mag got=%0d want=70", mag); end
    total++; if (ed !== 0) begin bad++; $display("FAIL l1_edge got=%0d want=0", ed); end
    total++; if (lat !== 2) begin bad++; $display("FAIL l1_latency got=%0d want=2", lat); end
  endtask

  task automatic test_modes();
    int mag, ed, lat;
    run_beat(-100, 60, 1, 100, mag, ed, lat);
    total++; if (mag !== 100) begin bad++; $display("FAIL linf_mag got=%0d want=100", mag); end
    total++; if (ed !== 1) begin bad++; $display("FAIL linf_edge_eq got=%0d want=1", ed); end
    run_beat(-100, 60, 2, 131, mag, ed, lat);
    total++; if (mag !== 130) begin bad++; $display("FAIL ambm_half_mag got=%0d want=130", mag); end
    total++; if (ed !== 0) begin bad++; $display("FAIL ambm_half_edge got=%0d want=0", ed); end
    run_beat(-100, 60, 3, 100, mag, ed, lat);
    total++; if (mag !== 118) begin bad++; $display("FAIL ambm_78_mag got=%0d want=118", mag); end
    run_beat(-128, -128, 1, 200, mag, ed, lat);
    total++; if (mag !== 128) begin bad++; $display("FAIL linf_minneg got=%0d want=128", mag); end
    total++; if (ed !== 0) begin bad++; $display("FAIL linf_minneg_edge got=%0d want=0", ed); end
    run_beat(-128, -128, 0, 255, mag, ed, lat);
    total++; if (mag !== 255) begin bad++; $display("FAIL l1_minneg_sat got=%0d want=255", mag); end
    total++; if (ed !== 1) begin bad++; $display("FAIL l1_minneg_edge got=%0d want=1", ed); end
  endtask

  // Three beats on consecutive cycles must emerge on consecutive cycles, two edges later.
  task automatic test_back_to_back();
    bus.ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(c < 3, 5 * (c + 1), 3, 1, 0);
      step();
      if (c + 1 >= 2 && c + 1 <= 4) begin
        total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL b2b_valid cyc=%0d got=%b want=1", c, bus.valid_o); end
        total++; if (int'(bus.mag_o) !== 5 * c) begin bad++; $display("FAIL b2b_mag cyc=%0d got=%0d want=%0d", c, bus.mag_o, 5 * c); end
      end else begin
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL b2b_idle cyc=%0d got=%b want=0", c, bus.valid_o); end
      end
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0, prev_mag = 0;
    bit prev_stall = 0, exp_rdy, acc;
    for (int c = 0; c < 40 && got < 6; c++) begin
      bus.ready_i = !(c >= 3 && c <= 7);
      drive(sent < 6, 10 * (sent + 1), 0, 0, 0);
      @(negedge clk);
      exp_rdy = !((sent - got) == 2 && !bus.ready_i);
      total++; if (bus.ready_o !== exp_rdy) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b want=%b", c, bus.ready_o, exp_rdy); end
      if (prev_stall) begin
        total++; if (int'(bus.mag_o) !== prev_mag) begin bad++; $display("FAIL bp_stable cyc=%0d got=%0d want=%0d", c, bus.mag_o, prev_mag); end
      end
      prev_stall = bus.valid_o && !bus.ready_i;
      prev_mag   = int'(bus.mag_o);
      acc = bus.valid_i && bus.ready_o;
      if (bus.valid_o && bus.ready_i) begin
        total++; if (int'(bus.mag_o) !== 10 * (got + 1)) begin bad++; $display("FAIL bp_order idx=%0d got=%0d want=%0d", got, bus.mag_o, 10 * (got + 1)); end
        got++;
      end
      if (acc) sent++;
      step();
    end
    bus.valid_i = 1'b0;
    total++; if (got !== 6) begin bad++; $display("FAIL bp_count got=%0d want=6", got); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int sent = 0, cyc = 0, gx, gy, m, th;
    bit acc, dlv;
    while (sent < 10000 && cyc < 60000) begin
      gx = ($urandom_range(0, 7) == 0) ? -128 : $signed(8'($urandom_range(0, 255)));
      gy = ($urandom_range(0, 7) == 0) ? -128 : $signed(8'($urandom_range(0, 255)));
      m  = $urandom_range(0, 3);
      th = $urandom_range(0, OMAX);
      drive($urandom_range(0, 1) == 1, gx, gy, m, th);
      bus.ready_i = $urandom_range(0, 1) == 1;
      @(negedge clk);
      acc = bus.valid_i && bus.ready_o;
      dlv = bus.valid_o && bus.ready_i;
      if (dlv) begin
        if (q.size() == 0) begin
          total++; bad++; $display("FAIL rnd_extra mag=%0d", bus.mag_o);
        end else begin
          e = q.pop_front();
          total++; if (int'(bus.mag_o) !== e.mag || int'(bus.edge_o) !== e.ed) begin
            bad++; $display("FAIL rnd_beat got=%0d/%0d want=%0d/%0d", bus.mag_o, bus.edge_o, e.mag, e.ed);
          end
        end
      end
      if (acc) begin
        e.mag = ref_mag(gx, gy, m);
        e.ed  = (e.mag >= th) ? 1 : 0;
        q.push_back(e);
        sent++;
      end
      step();
      cyc++;
    end
    total++; if (sent !== 10000) begin bad++; $display("FAIL rnd_budget sent=%0d want=10000", sent); end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        e = q.pop_front();
        total++; if (int'(bus.mag_o) !== e.mag || int'(bus.edge_o) !== e.ed) begin
          bad++; $display("FAIL rnd_drain got=%0d/%0d want=%0d/%0d", bus.mag_o, bus.edge_o, e.mag, e.ed);
        end
      end
      step();
    end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL rnd_left got=%0d want=0", q.size()); end
  endtask

  task automatic test_async_reset();
    bus.ready_i = 1'b0;
    drive(1'b1, 50, 10, 0, 0);
    step();
    drive(1'b1, 70, 10, 0, 0);
    step();
    bus.valid_i = 1'b0;
    step();
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL ar_loaded got=%b want=1", bus.valid_o); end
    #2 rstn = 1'b0;
    #1;
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", bus.valid_o); end
    total++; if (bus.mag_o !== 8'd0) begin bad++; $display("FAIL ar_mag got=%0d want=0", bus.mag_o); end
    total++; if (bus.edge_o !== 1'b0) begin bad++; $display("FAIL ar_edge got=%b want=0", bus.edge_o); end
    step();
    rstn = 1'b1;
    bus.ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL ar_stale cyc=%0d got=%b want=0", c, bus.valid_o); end
    end
  endtask

  initial begin
    test_reset();
    test_l1();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/magnitude_pipe.md
Name: magnitude_pipe

Overview:
Signed gradient-magnitude engine for the Sobel datapath. It takes one Gx/Gy pair per valid/ready beat and computes a run-time selectable magnitude approximation (L1, L-infinity, or alpha-max-beta-min). It saturates the result to the output width and flags pixels at or above a programmable edge threshold. It sits between the Sobel convolution stage and the output/threshold stage, and is fully back-pressurable through two registered pipeline stages.

Parameters:
WIDTH_P, 8, width of the two's-complement gx_i/gy_i inputs.
OUT_WIDTH_P, 8, width of the unsigned saturated magnitude output; legal range 1..WIDTH_P+1.

Ports:
clk_i  input  1  clock, rising edge.
rstn_i  input  1  asynchronous active-low reset.
valid_i  input  1  upstream beat valid.
ready_o  output  1  block can accept a beat this cycle.
gx_i  input  WIDTH_P  signed horizontal gradient.
gy_i  input  WIDTH_P  signed vertical gradient.
mode_i  input  2  magnitude mode; sampled together with the data beat.
thresh_i  input  OUT_WIDTH_P  edge threshold; sampled together with the data beat.
valid_o  output  1  output beat valid.
ready_i  input  1  downstream can accept a beat.
mag_o  output  OUT_WIDTH_P  saturated magnitude.
edge_o  output  1  1 when mag_o >= the threshold sampled with that beat.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rstn_i is asynchronous and active-low. During reset:
  - valid_o = 0, mag_o = 0, edge_o = 0, both stage-valid flags = 0.
  - ready_o = 1 immediately after reset deasserts.
- Handshake:
  - A beat is accepted when valid_i && ready_o.
  - A beat is delivered when valid_o && ready_i.
  - mag_o and edge_o stay stable while valid_o && !ready_i.
  - Data is never dropped or duplicated.
- Stage 1 (S1): on accept, registers the following.
  - ax = |gx_i| and ay = |gy_i|, each WIDTH_P bits unsigned. The most negative input, -2^(WIDTH_P-1), maps to 2^(WIDTH_P-1) with no overflow.
  - mode and thresh.
- Stage 2 (S2): registers the saturated result and the edge flag.
  - Working width is WIDTH_P+1 bits. mx = max(ax,ay), mn = min(ax,ay).
  - mode 0 (L1): ax + ay.
  - mode 1 (Linf): mx.
  - mode 2 (AMBM 1, 1/2): mx + (mn >> 1).
  - mode 3 (AMBM 7/8, 1/2): mx - (mx >> 3) + (mn >> 1).
  - All shifts truncate. Results cannot exceed 2^(WIDTH_P+1)-1.
  - Saturation: if the result exceeds 2^OUT_WIDTH_P - 1, mag = all ones; otherwise the low OUT_WIDTH_P bits.
  - edge = (mag >= thresh), using the saturated value.
- Latency and throughput:
  - Latency is exactly 2 cycles from accept to valid_o when unstalled.
  - Throughput is 1 beat per cycle.
- Stall rules:
  - S2 loads when S2 is empty or ready_i = 1.
  - S1 loads when S1 is empty or S1 is advancing into S2.
  - ready_o = !s1_valid || s2_load. This is combinational through ready_i. No skid buffer is required.
- Boundary conditions:
  - Simultaneous accept and deliver: both stages shift in the same cycle.
  - Full pipe: with both stages occupied and ready_i = 0, ready_o = 0 and the state holds.
  - Bubbles: a bubble in S1 collapses when S2 is drained.
- Run-time controls: mode_i and thresh_i changes affect only beats accepted afterwards. Beats already in flight keep their sampled values.
- Reset mid-operation: all in-flight beats are discarded and outputs return to their reset values asynchronously.

Decomposition:
- magnitude_pkg holds:
  - the mode enum mag_mode_e: MAG_L1=0, MAG_LINF=1, MAG_AMBM_HALF=2, MAG_AMBM_78=3;
  - the AMBM shift constants (beta shift 1, alpha shift 3).
- Sub-module: the existing elastic register, one instance per stage.
  - S1 payload width: 2*WIDTH_P+2+OUT_WIDTH_P.
  - S2 payload width: OUT_WIDTH_P+1.
  - The abs, select, saturate and compare logic stays inline.

Test Plan:
- Reset and idle (WIDTH_P=8, OUT_WIDTH_P=8): reset held -> valid_o=0, mag_o=0, edge_o=0; after release -> ready_o=1.
- L1 with saturation, thresh=100: gx=-128, gy=127 -> mag_o=255, edge=1; gx=30, gy=-40 -> mag_o=70, edge=0. Each result appears exactly 2 cycles after accept.
- Modes on gx=-100, gy=60:
  - mode1 -> 100;
  - mode2 -> 130;
  - mode3 -> 88 + 30 = 118;
  - gx=-128, gy=-128 in mode1 -> 128.
- Back-pressure: stream 6 beats with ready_i=0 for cycles 3-7.
  - ready_o drops once 2 beats are held.
  - mag_o stays stable while stalled.
  - All 6 beats emerge in order with none lost.
- Random valid_i/ready_i at 50% over 10k beats: scoreboard matches a reference model with mode/thresh changing every beat, and each beat uses its own sampled values.
- Async reset asserted with 2 beats in flight -> valid_o falls immediately; no stale beats appear after release.
